keypad_scan_ctrl: RTL

Scanning controller for the 4x4 matrix keypad: drives one column low at a time, samples the active-low row lines through a synchronizer, debounces a single-key press, and reports one hex key code per press. It sits between the keypad pins and the display/datapath logic. It replaces ad-hoc row decoding with a sequenced scan, and holds the active column while a key is down, which locks out ghost keys.

---
 rtl/keypad_scan_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with row synchronizer,
// press/release debounce and one-pulse hex key reporting.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                        SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  state_e        state_q;
  logic [3:0]    sync1_q;
  logic [3:0]    rs_q;
  logic [1:0]    c_q;
  logic [3:0]    col_q;
  logic [1:0]    row_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          held_q;

  logic          single_low;
  logic          match;
  logic [1:0]    row_idx;
  logic [1:0]    c_nxt;
  logic [3:0]    col_nxt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    map_code;

  assign single_low = $onehot(~rs_q);
  assign match      = (rs_q == ~(4'b0001 << row_q));
  assign c_nxt      = c_q + 2'd1;
  assign col_nxt    = ~(4'b0001 << c_nxt);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

  // Index of the single low row in the synchronized sample.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rs_q[i]) row_idx = 2'(i);
    end
  end

  // Hex legend of the key at the held column and captured row.
  always_comb begin
    map_code = 4'h0;
    unique case ({c_q, row_q})
      4'd0:  map_code = 4'hA;
      4'd1:  map_code = 4'h7;
      4'd2:  map_code = 4'h4;
      4'd3:  map_code = 4'h1;
      4'd4:  map_code = 4'h0;
      4'd5:  map_code = 4'h8;
      4'd6:  map_code = 4'h5;
      4'd7:  map_code = 4'h2;
      4'd8:  map_code = 4'hB;
      4'd9:  map_code = 4'h9;
      4'd10: map_code = 4'h6;
      4'd11: map_code = 4'h3;
      4'd12: map_code = 4'hF;
      4'd13: map_code = 4'hE;
      4'd14: map_code = 4'hD;
      default: map_code = 4'hC;
    endcase
  end

  // Two-flop synchronizer; idle rows read high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= row;
      rs_q    <= sync1_q;
    end
  end

  // Scan / debounce / press / release sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SCAN;
      c_q     <= 2'd0;
      col_q   <= 4'b1110;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_SCAN: begin
          if (cnt_q == SET_LAST) begin
            cnt_q <= '0;
            if (single_low) begin
              row_q   <= row_idx;
              state_q <= ST_DEBOUNCE;
            end else begin
              c_q   <= c_nxt;
              col_q <= col_nxt;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_DEBOUNCE: begin
          if (!match) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            code_q  <= map_code;
            valid_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (rs_q[row_q]) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
          end
        end
        ST_RELEASE: begin
          if (rs_q != 4'hF) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            c_q     <= c_nxt;
            col_q   <= col_nxt;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= ST_SCAN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
